dmem_arbiter: RTL

- Shares the single data-memory port of the single-cycle RISC-V core between two requesters:
  - port C: the core load/store path;
  - port D: a debug/DMA loader.
- Each requester uses a valid/ready request handshake and receives a one-cycle response pulse.
- Arbitration is two-way round-robin.
- One transaction is in flight at a time; the block sequences the memory strobes and read-data capture itself.
- Sits between the core/loader and the data memory. Its memory side carries address, write data, funct3 size code and read/write strobes.

---
 rtl/dmem_arb_pkg.sv | 32 +++
 rtl/dmem_arbiter_rr_arb2.sv | 29 ++
 rtl/dmem_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the core load/store path and
// the debug/DMA loader.
package dmem_arb_pkg;

    localparam int MAX_MEM_LAT = 4;
    localparam int REQ_AW      = 32;
    localparam int REQ_DW      = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT_C = 1'b0,
        PORT_D = 1'b1
    } port_id_t;

    typedef struct packed {
        logic              we;
        logic [REQ_AW-1:0] addr;
        logic [REQ_DW-1:0] wdata;
        logic [2:0]        funct3;
    } mem_req_t;

    // Performance counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker; the last-grant pointer lives in the parent.
import dmem_arb_pkg::*;

module rr_arb2 (
    input  logic     valid_c,
    input  logic     valid_d,
    input  port_id_t last_grant,
    output logic     grant_valid,
    output port_id_t grant_id
);

    // On a conflict the port that did not win last time goes first.
    always_comb begin
        grant_valid = valid_c | valid_d;
        grant_id    = PORT_C;
        if (valid_c && valid_d) begin
            if (last_grant == PORT_C) begin
                grant_id = PORT_D;
            end else begin
                grant_id = PORT_C;
            end
        end else if (valid_d) begin
            grant_id = PORT_D;
        end else begin
            grant_id = PORT_C;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the core (C) and a debug/DMA loader (D).
// One transaction in flight at a time. Define DMEM_ARB_PERF_EN to add grant/conflict counters.
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req_valid,
    output logic          c_req_ready,
    input  logic          c_req_we,
    input  logic [AW-1:0] c_req_addr,
    input  logic [DW-1:0] c_req_wdata,
    input  logic [2:0]    c_req_funct3,
    output logic          c_rsp_valid,
    output logic [DW-1:0] c_rsp_rdata,
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic          d_req_we,
    input  logic [AW-1:0] d_req_addr,
    input  logic [DW-1:0] d_req_wdata,
    input  logic [2:0]    d_req_funct3,
    output logic          d_rsp_valid,
    output logic [DW-1:0] d_rsp_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [2:0]    mem_funct3,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_c_grants,
    output logic [31:0]   perf_d_grants,
    output logic [31:0]   perf_conflicts
`endif
);

    localparam int                CNT_W    = $clog2(MAX_MEM_LAT);
    localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    if (MEM_LAT < 1 || MEM_LAT > MAX_MEM_LAT) begin : g_bad_mem_lat
        $error("dmem_arbiter: MEM_LAT must be in 1..4");
    end
    // The latched request record is shared with the RV32 core and is fixed at its width.
    if (AW != REQ_AW || DW != REQ_DW) begin : g_bad_width
        $error("dmem_arbiter: AW and DW must match the mem_req_t field widths");
    end

    arb_state_t       state_r;
    arb_state_t       state_d;
    port_id_t         last_grant_r;
    port_id_t         gid_r;
    port_id_t         grant_id_s;
    logic             grant_valid_s;
    logic             last_beat_s;
    mem_req_t         req_s;
    mem_req_t         req_r;
    logic [CNT_W-1:0] lat_cnt_r;
    logic             mem_read_r;
    logic             mem_write_r;
    logic             c_rsp_valid_r;
    logic             d_rsp_valid_r;
    logic [DW-1:0]    c_rsp_rdata_r;
    logic [DW-1:0]    d_rsp_rdata_r;

    rr_arb2 u_rr_arb2 (
        .valid_c     (c_req_valid),
        .valid_d     (d_req_valid),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    assign last_beat_s = (lat_cnt_r == LAT_LAST);

    // Ready is granted combinationally in IDLE; the payload mux follows the grant.
    always_comb begin
        c_req_ready  = 1'b0;
        d_req_ready  = 1'b0;
        req_s.we     = c_req_we;
        req_s.addr   = c_req_addr;
        req_s.wdata  = c_req_wdata;
        req_s.funct3 = c_req_funct3;
        if ((state_r == ARB_IDLE) && grant_valid_s) begin
            if (grant_id_s == PORT_D) begin
                d_req_ready  = 1'b1;
                req_s.we     = d_req_we;
                req_s.addr   = d_req_addr;
                req_s.wdata  = d_req_wdata;
                req_s.funct3 = d_req_funct3;
            end else begin
                c_req_ready  = 1'b1;
            end
        end else begin
            c_req_ready = 1'b0;
            d_req_ready = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (grant_valid_s) begin
                    state_d = ARB_ACCESS;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_ACCESS: begin
                if (last_beat_s) begin
                    state_d = ARB_RESP;
                end else begin
                    state_d = ARB_ACCESS;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_d;
        end
    end

    // Request latch, strobe sequencing and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r  <= PORT_D;
            gid_r         <= PORT_C;
            req_r         <= {$bits(mem_req_t){1'b0}};
            lat_cnt_r     <= CNT_ZERO;
            mem_read_r    <= 1'b0;
            mem_write_r   <= 1'b0;
            c_rsp_valid_r <= 1'b0;
            d_rsp_valid_r <= 1'b0;
            c_rsp_rdata_r <= {DW{1'b0}};
            d_rsp_rdata_r <= {DW{1'b0}};
        end else begin
            mem_write_r   <= 1'b0;
            c_rsp_valid_r <= 1'b0;
            d_rsp_valid_r <= 1'b0;
            case (state_r)
                ARB_IDLE: begin
                    if (grant_valid_s) begin
                        req_r        <= req_s;
                        gid_r        <= grant_id_s;
                        last_grant_r <= grant_id_s;
                        lat_cnt_r    <= CNT_ZERO;
                        mem_read_r   <= ~req_s.we;
                        mem_write_r  <= req_s.we;
                    end
                end
                ARB_ACCESS: begin
                    if (last_beat_s) begin
                        mem_read_r <= 1'b0;
                        if (gid_r == PORT_D) begin
                            d_rsp_valid_r <= 1'b1;
                            d_rsp_rdata_r <= req_r.we ? {DW{1'b0}} : mem_rdata;
                        end else begin
                            c_rsp_valid_r <= 1'b1;
                            c_rsp_rdata_r <= req_r.we ? {DW{1'b0}} : mem_rdata;
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r + CNT_ONE;
                    end
                end
                ARB_RESP: begin
                    lat_cnt_r <= CNT_ZERO;
                end
                default: begin
                    lat_cnt_r <= CNT_ZERO;
                end
            endcase
        end
    end

    assign mem_addr    = req_r.addr;
    assign mem_wdata   = req_r.wdata;
    assign mem_funct3  = req_r.funct3;
    assign mem_read    = mem_read_r;
    assign mem_write   = mem_write_r;
    assign c_rsp_valid = c_rsp_valid_r;
    assign d_rsp_valid = d_rsp_valid_r;
    assign c_rsp_rdata = c_rsp_rdata_r;
    assign d_rsp_rdata = d_rsp_rdata_r;

`ifdef DMEM_ARB_PERF_EN
    logic        conflict_s;
    logic [31:0] perf_c_r;
    logic [31:0] perf_d_r;
    logic [31:0] perf_conf_r;

    assign conflict_s = (state_r == ARB_IDLE) && c_req_valid && d_req_valid;

    // Saturating grant and conflict counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_c_r    <= 32'd0;
            perf_d_r    <= 32'd0;
            perf_conf_r <= 32'd0;
        end else begin
            if (c_req_ready) begin
                perf_c_r <= sat_inc32(perf_c_r);
            end
            if (d_req_ready) begin
                perf_d_r <= sat_inc32(perf_d_r);
            end
            if (conflict_s) begin
                perf_conf_r <= sat_inc32(perf_conf_r);
            end
        end
    end

    assign perf_c_grants  = perf_c_r;
    assign perf_d_grants  = perf_d_r;
    assign perf_conflicts = perf_conf_r;
`endif

endmodule
